// File: rtl/rv32_ctrl_pkg.sv
// Shared RV32I control definitions: opcode[6:2] values, control-field
// encodings and the multi-cycle FSM state encoding.
package rv32_ctrl_pkg;

    // Opcode bits [6:2]
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    // ALUOp operation classes (4-bit base encoding, zero-extended at the top)
    localparam logic [3:0] ALU_R     = 4'd0;
    localparam logic [3:0] ALU_LD    = 4'd1;
    localparam logic [3:0] ALU_ST    = 4'd2;
    localparam logic [3:0] ALU_BR    = 4'd3;
    localparam logic [3:0] ALU_I     = 4'd4;
    localparam logic [3:0] ALU_LUI   = 4'd5;
    localparam logic [3:0] ALU_AUIPC = 4'd6;
    localparam logic [3:0] ALU_JAL   = 4'd7;
    localparam logic [3:0] ALU_JALR  = 4'd8;

    // Branch (next-PC source) encodings
    localparam logic [1:0] BR_PC4  = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_JAL  = 2'b10;
    localparam logic [1:0] BR_JALR = 2'b11;

    // MemtoReg (writeback source) encodings
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_AUIPC = 2'b10;
    localparam logic [1:0] WB_PC4   = 2'b11;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_TRAP   = 3'd7
    } state_t;

endpackage

// File: rtl/rv32_op_decode.sv
// Combinational opcode classifier: maps opcode[6:2] to the static control
// fields used by the sequencer. SYSTEM is reported separately, not as legal.
module rv32_op_decode
    import rv32_ctrl_pkg::*;
(
    input  logic [4:0] op,
    output logic [3:0] alu_op,
    output logic       alu_src,
    output logic [1:0] mem_to_reg,
    output logic [1:0] jump,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_system,
    output logic       legal
);

    // Opcode lookup with safe defaults for unlisted encodings
    always_comb begin
        alu_op     = ALU_R;
        alu_src    = 1'b0;
        mem_to_reg = WB_ALU;
        jump       = BR_PC4;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_system  = 1'b0;
        legal      = 1'b1;
        case (op)
            OPC_OP:     alu_op = ALU_R;
            OPC_LOAD:   begin alu_op = ALU_LD; alu_src = 1'b1; mem_to_reg = WB_MEM; is_load = 1'b1; end
            OPC_STORE:  begin alu_op = ALU_ST; alu_src = 1'b1; is_store = 1'b1; end
            OPC_BRANCH: begin alu_op = ALU_BR; is_branch = 1'b1; end
            OPC_OP_IMM: begin alu_op = ALU_I; alu_src = 1'b1; end
            OPC_LUI:    begin alu_op = ALU_LUI; alu_src = 1'b1; end
            OPC_AUIPC:  begin alu_op = ALU_AUIPC; alu_src = 1'b1; mem_to_reg = WB_AUIPC; end
            OPC_JAL:    begin alu_op = ALU_JAL; alu_src = 1'b1; mem_to_reg = WB_PC4; jump = BR_JAL; end
            OPC_JALR:   begin alu_op = ALU_JALR; alu_src = 1'b1; mem_to_reg = WB_PC4; jump = BR_JALR; end
            OPC_SYSTEM: begin is_system = 1'b1; legal = 1'b0; end
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// memory request/ready handshake, stall timeout, halt and trap states.
// Handshake: mem_req is held high for the whole FETCH/MEM state; the access
// completes in the cycle mem_ready is seen high while mem_req is high.
module multicycle_control_unit
    import rv32_ctrl_pkg::*;
#(
    parameter int ALUOP_W        = 4,
    parameter int MEM_WAIT_MAX   = 15,
    parameter bit HALT_ON_SYSTEM = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         Branch,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [1:0]         MemtoReg,
    output logic               ALUSrc,
    output logic               RegWrite,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               halt,
    output logic               trap,
    output logic               retire
);

    localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_t           state, state_n;
    logic [4:0]       op_q;
    logic [CNT_W-1:0] wait_cnt;

    logic [4:0] dec_in;
    logic [3:0] dec_alu_op;
    logic       dec_alu_src, dec_load, dec_store, dec_branch, dec_system, dec_legal;
    logic [1:0] dec_m2r, dec_jump;
    logic       stall, timeout;

    // In DECODE the live opcode is classified to pick the next state; in every
    // other state the latched op_q drives the control fields.
    assign dec_in = (state == ST_DECODE) ? opcode : op_q;

    rv32_op_decode u_dec (
        .op         (dec_in),
        .alu_op     (dec_alu_op),
        .alu_src    (dec_alu_src),
        .mem_to_reg (dec_m2r),
        .jump       (dec_jump),
        .is_load    (dec_load),
        .is_store   (dec_store),
        .is_branch  (dec_branch),
        .is_system  (dec_system),
        .legal      (dec_legal)
    );

    assign stall   = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
    assign timeout = (MEM_WAIT_MAX != 0) && (wait_cnt == CNT_W'(MEM_WAIT_MAX));

    // State register, latched opcode and saturating stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_BOOT;
            op_q     <= 5'd0;
            wait_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == ST_DECODE)
                op_q <= opcode;
            if (!stall)
                wait_cnt <= '0;
            else if (wait_cnt != {CNT_W{1'b1}})
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Next-state and control outputs. Everything is a function of state and
    // op_q except the completion strobes (IRWrite, store PCWrite/retire),
    // which fire only in the cycle the memory access actually completes.
    always_comb begin
        state_n  = state;
        mem_req  = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = BR_PC4;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = WB_ALU;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        ALUOp    = '0;
        halt     = 1'b0;
        trap     = 1'b0;
        retire   = 1'b0;
        case (state)
            ST_BOOT: state_n = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    state_n = ST_DECODE;
                end else if (timeout) begin
                    state_n = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (dec_system)
                    state_n = HALT_ON_SYSTEM ? ST_HALT : ST_TRAP;
                else if (!dec_legal)
                    state_n = ST_TRAP;
                else
                    state_n = ST_EXEC;
            end
            ST_EXEC: begin
                ALUOp  = ALUOP_W'(dec_alu_op);
                ALUSrc = dec_alu_src;
                if (dec_branch) begin
                    Branch  = BR_COND;
                    PCWrite = 1'b1;
                    retire  = 1'b1;
                    state_n = ST_FETCH;
                end else if (dec_load || dec_store) begin
                    state_n = ST_MEM;
                end else begin
                    state_n = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                ALUSrc   = 1'b1;
                MemRead  = dec_load;
                MemWrite = dec_store;
                if (mem_ready) begin
                    if (dec_store) begin
                        PCWrite = 1'b1;
                        retire  = 1'b1;
                        state_n = ST_FETCH;
                    end else begin
                        state_n = ST_WB;
                    end
                end else if (timeout) begin
                    state_n = ST_TRAP;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                MemtoReg = dec_m2r;
                Branch   = dec_jump;
                ALUOp    = ALUOP_W'(dec_alu_op);
                ALUSrc   = dec_alu_src;
                PCWrite  = 1'b1;
                retire   = 1'b1;
                state_n  = ST_FETCH;
            end
            ST_HALT: halt = 1'b1;
            ST_TRAP: trap = 1'b1;
            default: state_n = ST_BOOT;
        endcase
    end

endmodule
